// File: rtl/dwconv_streamer.sv
// dwconv_streamer: reads a feature map from SRAM, streams it to the dwconv core, and writes its results back.
// Define DWCONV_STREAMER_ZERO_PAD_EN to stream a zero-bordered (IMG_W+2)x(IMG_H+2) frame.
module dwconv_streamer #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int ADDR_W  = 10,
   parameter int OUT_CNT = IMG_W * IMG_H,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [143:0]      weight_cfg,
   input  logic [15:0]       bias_cfg,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       rd_data,
   output logic              in_valid,
   output logic [15:0]       in_data,
   output logic [143:0]      weight,
   output logic [15:0]       bias,
   input  logic              out_valid,
   input  logic [15:0]       sum,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data
);

`ifdef DWCONV_STREAMER_ZERO_PAD_EN
   localparam int STR_W = IMG_W + 2;
   localparam int STR_H = IMG_H + 2;
`else
   localparam int STR_W = IMG_W;
   localparam int STR_H = IMG_H;
`endif
   localparam int CNT_W = ADDR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(STR_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(STR_H - 1);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_CNT);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  col_q, col_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
   logic [TO_W-1:0]   drain_q, drain_d;
   logic              err_q, err_d;
   logic [143:0]      weight_q, weight_d;
   logic [15:0]       bias_q, bias_d;
   logic              in_valid_q, in_valid_d;
   logic              in_mem_q, in_mem_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;

   logic border;
   logic accept_res;

`ifdef DWCONV_STREAMER_ZERO_PAD_EN
   assign border = (row_q == '0) || (row_q == ROW_LAST) ||
                   (col_q == '0) || (col_q == COL_LAST);
`else
   assign border = 1'b0;
`endif

   assign accept_res = (state_q == S_READ) || (state_q == S_DRAIN);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      addr_d     = addr_q;
      res_cnt_d  = res_cnt_q;
      drain_d    = drain_q;
      err_d      = err_q;
      weight_d   = weight_q;
      bias_d     = bias_q;
      in_valid_d = 1'b0;
      in_mem_d   = 1'b0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy       = 1'b0;
      done       = 1'b0;
      rd_en      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_READ;
               weight_d  = weight_cfg;
               bias_d    = bias_cfg;
               err_d     = 1'b0;
               col_d     = '0;
               row_d     = '0;
               addr_d    = '0;
               res_cnt_d = '0;
               drain_d   = '0;
            end
         end
         S_READ: begin
            busy       = 1'b1;
            rd_en      = ~border;
            in_valid_d = 1'b1;
            in_mem_d   = ~border;
            if (!border) begin
               addr_d = addr_q + 1'b1;
            end
            if (col_q == COL_LAST) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
            if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
               state_d = S_DRAIN;
               drain_d = '0;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            drain_d = drain_q + 1'b1;
            // a completed frame wins over a timeout in the same cycle
            if (res_cnt_q == OUT_LAST) begin
               state_d = S_DONE;
            end else if (drain_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (out_valid && accept_res && (res_cnt_q < OUT_LAST)) begin
         wr_en_d   = 1'b1;
         wr_addr_d = res_cnt_q[ADDR_W-1:0];
         wr_data_d = sum;
         res_cnt_d = res_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         addr_q     <= '0;
         res_cnt_q  <= '0;
         drain_q    <= '0;
         err_q      <= 1'b0;
         weight_q   <= '0;
         bias_q     <= '0;
         in_valid_q <= 1'b0;
         in_mem_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         addr_q     <= addr_d;
         res_cnt_q  <= res_cnt_d;
         drain_q    <= drain_d;
         err_q      <= err_d;
         weight_q   <= weight_d;
         bias_q     <= bias_d;
         in_valid_q <= in_valid_d;
         in_mem_q   <= in_mem_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // SRAM data arrives the cycle after the read, so it passes straight through
   assign in_data  = in_mem_q ? rd_data : '0;
   assign in_valid = in_valid_q;
   assign rd_addr  = rd_en ? addr_q : '0;
   assign err      = err_q;
   assign weight   = weight_q;
   assign bias     = bias_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_dwconv_streamer.sv
// Scoreboard bench for dwconv_streamer: stimulus pushes expected beats,
// a negedge monitor pops and compares in_data and result writes.
`timescale 1ns/1ps
module tb_dwconv_streamer;

   localparam int W   = 8;
   localparam int H   = 8;
   localparam int AW  = 10;
   localparam int N   = W * H;
   localparam int TMO = 1023;
`ifdef DWCONV_STREAMER_ZERO_PAD_EN
   localparam int N_IN     = (W + 2) * (H + 2);
   localparam int FIRST_RD = W + 4;
`else
   localparam int N_IN     = N;
   localparam int FIRST_RD = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [143:0]  weight_cfg;
   logic [15:0]   bias_cfg;
   logic          busy, done, err;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data = '0;
   logic          in_valid;
   logic [15:0]   in_data;
   logic [143:0]  weight;
   logic [15:0]   bias;
   logic          out_valid;
   logic [15:0]   sum;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;

   dwconv_streamer #(
      .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .OUT_CNT(N), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .weight_cfg(weight_cfg), .bias_cfg(bias_cfg),
      .busy(busy), .done(done), .err(err),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .in_valid(in_valid), .in_data(in_data),
      .weight(weight), .bias(bias),
      .out_valid(out_valid), .sum(sum),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   logic [15:0] mem [0:1023];
   logic [15:0] res_mem [0:1023];
   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 16'(i);
         res_mem[i] = '0;
      end
   end

   initial forever begin
      @(posedge clk);
      if (rd_en) rd_data <= mem[rd_addr];
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input logic [143:0] act,
                        input logic [143:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [15:0] pat(input int k);
      return 16'(k * 37 + 256) ^ 16'h8000;
   endfunction

   logic [15:0] exp_in [$];
   logic [25:0] exp_wr [$];

   int rd_cnt, in_cnt, in_runs, wr_cnt, done_cnt;
   int first_rd_cyc, first_in_cyc, last_in_cyc, done_cyc;
   int last_wr_addr, rd_total = 0, wr_total = 0, exp_rd;
   logic         done_err;
   logic [143:0] done_w;
   logic [15:0]  done_b;
   logic         busy_prev = 1'b0, in_prev = 1'b0;

   initial forever begin
      logic [15:0] e;
      logic [25:0] ew;
      @(negedge clk);
      if (!rst_n) begin
         busy_prev = 1'b0;
         in_prev   = 1'b0;
      end else begin
         if (busy && !busy_prev) begin
            rd_cnt = 0; in_cnt = 0; in_runs = 0; wr_cnt = 0;
            done_cnt = 0; exp_rd = 0; last_wr_addr = -1;
         end
         busy_prev = busy;
         if (rd_en) begin
            if (rd_cnt == 0) first_rd_cyc = cyc;
            check("rd_addr", 144'(rd_addr), 144'(exp_rd));
            exp_rd++;
            rd_cnt++;
            rd_total++;
         end
         if (in_valid) begin
            if (!in_prev) in_runs++;
            if (in_cnt == 0) first_in_cyc = cyc;
            last_in_cyc = cyc;
            in_cnt++;
            if (exp_in.size() == 0) begin
               n_chk++;
               $display("FAIL in_extra: got in_data %0h, expected no beat", in_data);
            end else begin
               e = exp_in.pop_front();
               check("in_data", 144'(in_data), 144'(e));
            end
         end
         in_prev = in_valid;
         if (wr_en) begin
            wr_cnt++;
            wr_total++;
            last_wr_addr = int'(wr_addr);
            res_mem[wr_addr] = wr_data;
            if (exp_wr.size() == 0) begin
               n_chk++;
               $display("FAIL wr_extra: got write %0h@%0d, expected none", wr_data, wr_addr);
            end else begin
               ew = exp_wr.pop_front();
               check("wr_beat", 144'({wr_addr, wr_data}), 144'(ew));
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
            done_w   = weight;
            done_b   = bias;
         end
      end
   end

   int acc_cyc;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [143:0] w, input logic [15:0] b);
`ifdef DWCONV_STREAMER_ZERO_PAD_EN
      for (int r = 0; r < H + 2; r++)
         for (int c = 0; c < W + 2; c++)
            if (r == 0 || r == H + 1 || c == 0 || c == W + 1) exp_in.push_back(16'h0);
            else exp_in.push_back(16'((r - 1) * W + (c - 1)));
`else
      for (int i = 0; i < N; i++) exp_in.push_back(16'(i));
`endif
      weight_cfg = w;
      bias_cfg   = b;
      start      = 1'b1;
      step();
      start   = 1'b0;
      acc_cyc = cyc - 1;
   endtask

   task automatic drive_beats(input int n);
      for (int k = 0; k < n; k++) begin
         out_valid = 1'b1;
         sum       = pat(k);
         if (k < N) exp_wr.push_back({10'(k), pat(k)});
         step();
      end
      out_valid = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (done_cnt == 0 && i < 3000) begin
         step();
         i++;
      end
      repeat (3) step();
      check("done_pulses", 144'(done_cnt), 144'(1));
   endtask

   task automatic frame_common(input int nwr, input logic e);
      check("rd_count", 144'(rd_cnt), 144'(N));
      check("in_count", 144'(in_cnt), 144'(N_IN));
      check("in_runs", 144'(in_runs), 144'(1));
      check("wr_count", 144'(wr_cnt), 144'(nwr));
      check("err_at_done", 144'(done_err), 144'(e));
      check("in_q_left", 144'(exp_in.size()), 144'(0));
      check("wr_q_left", 144'(exp_wr.size()), 144'(0));
   endtask

   localparam logic [143:0] W1 = {9{16'h0001}};
   localparam logic [143:0] W2 =
      144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;

   initial begin
      int mism;
      int rt, wt, i;
      rst_n = 1'b0; start = 1'b0; out_valid = 1'b0; sum = '0;
      weight_cfg = '0; bias_cfg = '0;
      step(); step();
      check("rst_outputs", 144'({busy, done, err, rd_en, rd_addr, in_valid,
            in_data, wr_en, wr_addr, wr_data}), '0);
      check("rst_weight", weight, '0);
      check("rst_bias", 144'(bias), '0);
      rst_n = 1'b1;
      step(); step();

      // basic frame
      start_frame(W1, 16'h0000);
      repeat (3) step();
      drive_beats(N);
      wait_done();
      check("first_rd_lat", 144'(first_rd_cyc - acc_cyc), 144'(FIRST_RD));
      check("first_in_lat", 144'(first_in_cyc - acc_cyc), 144'(2));
      frame_common(N, 1'b0);
      mism = 0;
      for (int k = 0; k < N; k++) if (res_mem[k] !== pat(k)) mism++;
      check("result_sram", 144'(mism), 144'(0));

      // config hold and ignored mid-frame start
      start_frame(W2, 16'hFF85);
      i = 0;
      while (rd_addr != 10'd10 && i < 200) begin step(); i++; end
      weight_cfg = ~W2;
      bias_cfg   = 16'h1234;
      start      = 1'b1;
      step();
      start = 1'b0;
      check("weight_hold", weight, W2);
      check("bias_hold", 144'(bias), 144'(16'hFF85));
      drive_beats(N);
      wait_done();
      check("weight_at_done", done_w, W2);
      check("bias_at_done", 144'(done_b), 144'(16'hFF85));
      frame_common(N, 1'b0);

      // timeout: four results never arrive
      start_frame(W1, 16'h0005);
      repeat (3) step();
      drive_beats(60);
      wait_done();
      check("timeout_delay", 144'(done_cyc - last_in_cyc), 144'(TMO));
      check("timeout_last_wr", 144'(last_wr_addr), 144'(59));
      frame_common(60, 1'b1);

      // surplus results; this start must also clear err
      start_frame(W1, 16'h0000);
      check("err_cleared", 144'(err), 144'(0));
      drive_beats(N + 2);
      wait_done();
      check("surplus_last_wr", 144'(last_wr_addr), 144'(N - 1));
      frame_common(N, 1'b0);

      // reset mid-frame
      start_frame(W1, 16'h0000);
      i = 0;
      while (rd_addr != 10'd20 && i < 200) begin step(); i++; end
      check("reached_addr20", 144'(rd_addr), 144'(20));
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 144'({busy, done, err, rd_en, rd_addr, in_valid,
            in_data, wr_en, wr_addr, wr_data}), '0);
      check("midrst_cfg", 144'({weight, bias} != '0), 144'(0));
      exp_in.delete();
      exp_wr.delete();
      step(); step();
      rst_n = 1'b1;
      rt = rd_total;
      wt = wr_total;
      out_valid = 1'b1;
      sum = 16'h5A5A;
      step(); step();
      out_valid = 1'b0;
      repeat (8) step();
      check("idle_no_reads", 144'(rd_total - rt), 144'(0));
      check("idle_no_writes", 144'(wr_total - wt), 144'(0));
      start_frame(W1, 16'h0000);
      repeat (3) step();
      drive_beats(N);
      wait_done();
      check("restart_rd_lat", 144'(first_rd_cyc - acc_cyc), 144'(FIRST_RD));
      frame_common(N, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dwconv_streamer.md
Name: dwconv_streamer

Overview:
Frame-level driver and collector for the depthwise 3x3 convolution core. It reads one single-channel feature map from a synchronous SRAM and streams it in raster order on the core's in_valid/in_data interface. It holds the kernel weights and bias stable for the whole frame. It collects every out_valid/sum result and writes it back to a result SRAM.

Parameters:
IMG_W, 8, feature-map width in pixels (>=3)
IMG_H, 8, feature-map height in pixels (>=3)
ADDR_W, 10, SRAM address width; 2^ADDR_W must be >= streamed pixel count
OUT_CNT, IMG_W*IMG_H, number of out_valid beats expected per frame
TIMEOUT, 1023, maximum cycles in DRAIN waiting for results

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  frame start request, sampled in IDLE only
weight_cfg  input  144  nine signed 16-bit taps, tap0 in [15:0], captured on accepted start
bias_cfg  input  16  bias, captured on accepted start
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at frame completion
err  output  1  sticky timeout flag, cleared by next accepted start
rd_en  output  1  feature SRAM read enable
rd_addr  output  ADDR_W  feature SRAM address
rd_data  input  16  feature SRAM data, valid exactly 1 cycle after rd_en
in_valid  output  1  to core: pixel valid
in_data  output  16  to core: signed pixel
weight  output  144  to core: held weight_cfg
bias  output  16  to core: held bias_cfg
out_valid  input  1  from core: result valid
sum  input  16  from core: signed result
wr_en  output  1  result SRAM write enable
wr_addr  output  ADDR_W  result SRAM address
wr_data  output  16  result SRAM data

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and all counters are 0.
- FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 captures the cfg inputs into weight/bias, clears err, sets busy, and goes to READ. start in any other state is ignored.
- READ: rd_en=1 every cycle, with rd_addr counting 0..N-1 (N = IMG_W*IMG_H, or padded size, see feature). After address N-1 is issued, go to DRAIN.
- Stream timing: in_valid and in_data are rd_en and rd_data delayed one cycle. in_valid is one contiguous N-cycle burst with no bubbles.
- Latency: start sampled at cycle 0 -> rd_en/rd_addr=0 at cycle 1 -> in_valid with mem[0] at cycle 2.
- weight/bias: change only on an accepted start and stay stable through DONE.
- Result path: each out_valid=1 cycle registers wr_en=1, wr_data=sum, wr_addr=result counter (1-cycle latency), then the counter increments. This is accepted in READ and DRAIN. out_valid in IDLE/DONE is ignored, and no write occurs.
- DRAIN: once the result counter reaches OUT_CNT (including the final write), go to DONE.
- Timeout: if the drain cycle counter reaches TIMEOUT, set err=1 and go to DONE.
- Surplus results: any out_valid beyond OUT_CNT is dropped, and wr_en stays 0.
- DONE: done=1 for one cycle, busy drops the same cycle, and the FSM returns to IDLE. A start in the following cycle is accepted.
- Reset mid-frame: all state clears immediately and asynchronously. No further rd_en/wr_en occur until a new start.
- Arithmetic: no arithmetic on data. Address counters are unsigned, ADDR_W bits, and do not wrap within a legal frame.

Optional Feature:
DWCONV_STREAMER_ZERO_PAD_EN.
- Defined: the streamed frame is (IMG_W+2)x(IMG_H+2). Border positions send in_data=0 with in_valid=1 and no SRAM read (rd_en=0 that slot). Interior positions read SRAM addresses 0..IMG_W*IMG_H-1 in raster order. The in_valid burst remains contiguous.
- Undefined: an unpadded IMG_W*IMG_H stream with a read on every slot.

Test Plan:
1. Basic frame:
   - Stimulus: 8x8 map mem[i]=i, weight_cfg all taps 1, bias 0, start pulse at cycle 0.
   - Response: rd_en is high cycles 1..64 with rd_addr 0..63. in_valid is high cycles 2..65 with in_data 0..63. After 64 model-driven out_valid beats, the result SRAM equals the model, done pulses once, and err=0.
2. Config hold:
   - Stimulus: change weight_cfg/bias_cfg mid-frame.
   - Response: weight/bias outputs keep their start-time values. A second start pulsed mid-frame is ignored (rd_addr sequence unbroken).
3. Timeout:
   - Stimulus: the core drives only 60 of 64 out_valid beats.
   - Response: err=1 and done pulses TIMEOUT cycles after DRAIN entry. wr_addr reached 59. A new start clears err.
4. Surplus results:
   - Stimulus: 66 out_valid beats.
   - Response: exactly 64 writes occur, and no write to addresses 64/65.
5. Reset mid-frame:
   - Stimulus: rst_n low at rd_addr=20.
   - Response: all outputs are 0 the same cycle. A restart streams from address 0 again.
6. With DWCONV_STREAMER_ZERO_PAD_EN:
   - Stimulus: 8x8 frame.
   - Response: 100 contiguous in_valid cycles, border values 0, interior values mem[0..63] in order, and exactly 64 rd_en cycles.
